// File: rtl/siso_frame_rx.sv
// Serial frame receiver for the SISO delay-line output.
// Frame on sin: start bit 1, WIDTH data bits LSB-first, optional even-parity bit, stop bit 0.
// The received word is offered on a valid/ready port together with its error flags.
module siso_frame_rx #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,         // asynchronous, active-low
  input  logic             sin,         // serial line, idles at 0
  input  logic             out_ready,
  input  logic             ovr_clr,     // synchronous clear of overrun
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun,     // sticky: a completed frame was dropped
  output logic             busy
);

  // Wide enough to hold WIDTH, so the counter cannot wrap mid-frame.
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [WIDTH-1:0]  shreg_q;
  logic              par_q;

  logic              last_bit;
  logic              can_load;
  logic              par_calc;

  // Decode of the current frame position and delivery condition.
  always_comb begin
    last_bit = (cnt_q == CntW'(WIDTH - 1));
    // A new word may load when the port is empty or is emptied on this same edge.
    can_load = !out_valid || out_ready;
    par_calc = PARITY_EN ? (^shreg_q ^ par_q) : 1'b0;
  end

  // Receive FSM with registered output port, handshake and overrun tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      // Transfer empties the port; a load in StStop below overrides this.
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      // Clear first so a drop on the same edge wins.
      if (ovr_clr) begin
        overrun <= 1'b0;
      end

      case (state_q)
        StIdle: begin
          if (sin) begin
            state_q <= StData;
            cnt_q   <= '0;
          end
        end
        StData: begin
          shreg_q <= {sin, shreg_q[WIDTH-1:1]};
          cnt_q   <= cnt_q + CntW'(1);
          if (last_bit) begin
            state_q <= PARITY_EN ? StParity : StStop;
          end
        end
        StParity: begin
          par_q   <= sin;
          state_q <= StStop;
        end
        StStop: begin
          if (can_load) begin
            out_data   <= shreg_q;
            out_valid  <= 1'b1;
            parity_err <= par_calc;
            frame_err  <= sin;
          end else begin
            overrun <= 1'b1;
          end
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Busy whenever a frame is in progress.
  always_comb begin
    busy = (state_q != StIdle);
  end

endmodule
